// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory subsystem.
// Widths are reused by the memory model and the fetch unit. The state encoding is fixed so that
// other blocks and debug tooling can decode the raw state value.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W     = 64;
  localparam int unsigned IMEM_DATA_W     = 32;
  localparam int unsigned IMEM_DEPTH_LOG2 = 8;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    StBoot  = ST_BOOT,
    StRun   = ST_RUN,
    StDrain = ST_DRAIN
  } imem_state_e;

endpackage

// File: rtl/imem_addr_check.sv
// Combinational address legality check for one requester.
// A byte address is bad if it is not half-word aligned or lies beyond the memory depth.
// Ports:
//   addr_i  byte address from a requester
//   bad_o   1 = address must not reach the memory
module imem_addr_check
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned DEPTH_LOG2 = IMEM_DEPTH_LOG2
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              bad_o
);

  assign bad_o = addr_i[0] | (|addr_i[ADDR_W-1:DEPTH_LOG2+1]);

endmodule

// File: rtl/imem_access_ctrl.sv
// Shares the single-port instruction memory between the boot loader (writes) and the core fetch
// unit (reads). Holds the core in reset until the image is loaded, gives fetch fixed priority in
// RUN, and forces a loader grant after MAX_WAIT consecutive denied loader cycles.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   boot_mode_i                     level request to (re)enter BOOT
//   ld_req_i/ld_addr_i/ld_data_i/ld_last_i, ld_gnt_o   loader write channel
//   if_req_i/if_addr_i, if_gnt_o    fetch request channel
//   if_rdata_o/if_rvalid_o/if_err_o registered fetch response (one cycle after if_gnt_o)
//   mem_*                           single-port memory interface (read data is combinational)
//   core_run_o                      1 = core released from reset
//   load_count_o                    words written since entering BOOT (saturating)
module imem_access_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned DATA_W     = IMEM_DATA_W,
  parameter int unsigned DEPTH_LOG2 = IMEM_DEPTH_LOG2,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_mode_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_gnt_o,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_rvalid_o,
  output logic              if_err_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_write_en_o,
  output logic              mem_read_en_o,
  input  logic [DATA_W-1:0] mem_read_data_i,
  output logic              core_run_o,
  output logic [15:0]       load_count_o
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  imem_state_e       state_q;
  logic              active_q;
  logic              if_rvalid_q;
  logic              if_err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              core_run_q;
  logic [15:0]       load_count_q;
  logic [7:0]        wait_q;

  logic ld_bad;
  logic if_bad;
  logic force_grant;

  imem_addr_check #(
    .ADDR_W     (ADDR_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ld_check (
    .addr_i (ld_addr_i),
    .bad_o  (ld_bad)
  );

  imem_addr_check #(
    .ADDR_W     (ADDR_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_if_check (
    .addr_i (if_addr_i),
    .bad_o  (if_bad)
  );

  assign force_grant = (wait_q == MaxWait);

  // Grants are combinational; nothing is granted until the first edge after reset release.
  always_comb begin
    ld_gnt_o = 1'b0;
    if_gnt_o = 1'b0;
    if (active_q) begin
      case (state_q)
        StBoot: ld_gnt_o = ld_req_i;
        StRun: begin
          // The cycle that sees boot_mode is the transition cycle: no grants.
          if (!boot_mode_i) begin
            if_gnt_o = if_req_i & ~force_grant;
            ld_gnt_o = ld_req_i & (~if_req_i | force_grant);
          end
        end
        default: ;
      endcase
    end
  end

  // Bad addresses are still granted (acknowledged) but never reach the memory.
  assign mem_write_en_o   = ld_gnt_o & ~ld_bad;
  assign mem_read_en_o    = if_gnt_o & ~if_bad;
  assign mem_address_o    = if_gnt_o ? if_addr_i : ld_addr_i;
  assign mem_write_data_o = ld_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      active_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      core_run_q   <= 1'b0;
      load_count_q <= '0;
      wait_q       <= '0;
    end else begin
      active_q    <= 1'b1;
      if_rvalid_q <= if_gnt_o;
      if_err_q    <= if_gnt_o & if_bad;
      if (if_gnt_o) begin
        if_rdata_q <= if_bad ? '0 : mem_read_data_i;
      end

      case (state_q)
        StBoot: begin
          wait_q <= '0;
          if (mem_write_en_o && (load_count_q != 16'hFFFF)) begin
            load_count_q <= load_count_q + 16'd1;
          end
          if (ld_gnt_o && ld_last_i && !boot_mode_i) begin
            state_q    <= StRun;
            core_run_q <= 1'b1;
          end
        end
        StRun: begin
          if (ld_req_i && !ld_gnt_o) begin
            wait_q <= wait_q + 8'd1;
          end else begin
            wait_q <= '0;
          end
          if (boot_mode_i) begin
            state_q    <= StDrain;
            core_run_q <= 1'b0;
          end
        end
        StDrain: begin
          // One idle cycle lets the last fetch response retire before BOOT.
          state_q      <= StBoot;
          load_count_q <= '0;
          wait_q       <= '0;
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  assign if_rvalid_o  = if_rvalid_q;
  assign if_err_o     = if_err_q;
  assign if_rdata_o   = if_rdata_q;
  assign core_run_o   = core_run_q;
  assign load_count_o = load_count_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl with a word memory behind it. Expected fetch responses are pushed
// to a scoreboard when a grant is seen and popped when the response is due one cycle later.
module tb_imem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        boot_mode;
  logic        ld_req;
  logic [63:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_gnt;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  logic        if_err;
  logic [63:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_read_data;
  logic        core_run;
  logic [15:0] load_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [31:0] ref_mem [256];
  logic [31:0] mem [256];

  imem_access_ctrl u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .boot_mode_i      (boot_mode),
    .ld_req_i         (ld_req),
    .ld_addr_i        (ld_addr),
    .ld_data_i        (ld_data),
    .ld_last_i        (ld_last),
    .ld_gnt_o         (ld_gnt),
    .if_req_i         (if_req),
    .if_addr_i        (if_addr),
    .if_gnt_o         (if_gnt),
    .if_rdata_o       (if_rdata),
    .if_rvalid_o      (if_rvalid),
    .if_err_o         (if_err),
    .mem_address_o    (mem_address),
    .mem_write_data_o (mem_write_data),
    .mem_write_en_o   (mem_write_en),
    .mem_read_en_o    (mem_read_en),
    .mem_read_data_i  (mem_read_data),
    .core_run_o       (core_run),
    .load_count_o     (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[8:1]] <= mem_write_data;
  end
  assign mem_read_data = mem[mem_address[8:1]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [63:0] a);
    return a[0] || (a[63:9] != '0);
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (sb_q.size() > 0) begin
        sb_e = sb_q.pop_front();
        check("rvalid", if_rvalid, 1);
        check("rdata", if_rdata, sb_e.data);
        check("rerr", if_err, sb_e.err);
      end else begin
        check("rvalid_idle", if_rvalid, 0);
      end
      if (if_gnt) begin
        if (addr_bad(if_addr)) sb_q.push_back('{data: 32'h0, err: 1'b1});
        else sb_q.push_back('{data: ref_mem[if_addr[8:1]], err: 1'b0});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    rst_n = 1'b0; boot_mode = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    if_req = 1'b0; if_addr = '0;
    #2;
    check("rst_core_run", core_run, 0);
    check("rst_load_count", load_count, 0);
    check("rst_rvalid", if_rvalid, 0);
    check("rst_rdata", if_rdata, 0);
    check("rst_err", if_err, 0);

    // 1: boot image load
    @(posedge clk); #1;
    rst_n = 1'b1;
    ld_req = 1'b1; ld_addr = 64'h0; ld_data = 32'hA000_0000;
    #1 check("inactive_ld_gnt", ld_gnt, 0);
    check("inactive_wen", mem_write_en, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      ld_req = 1'b1; ld_addr = 64'(2 * i); ld_data = 32'hA000_0000 + 32'(i);
      ld_last = (i == 3);
      ref_mem[i] = ld_data;
      #1 check("boot_ld_gnt", ld_gnt, 1);
      check("boot_wen", mem_write_en, 1);
      check("boot_if_gnt", if_gnt, 0);
      if (i < 3) check("boot_core_run", core_run, 0);
      tick();
    end
    ld_req = 1'b0; ld_last = 1'b0;
    check("run_core_run", core_run, 1);
    check("run_load_count", load_count, 4);

    // 2: single fetch
    if_req = 1'b1; if_addr = 64'h2;
    #1 check("fetch_gnt", if_gnt, 1);
    check("fetch_ren", mem_read_en, 1);
    tick();
    if_req = 1'b0;
    tick();

    // 3: anti-starvation
    ld_req = 1'b1; ld_addr = 64'h10; ld_data = 32'h1234_5678; if_req = 1'b1;
    for (int k = 0; k < 27; k++) begin
      if_addr = 64'(2 * (k % 4));
      #1 check("starve_ld_gnt", ld_gnt, (k % 9) == 8);
      check("starve_if_gnt", if_gnt, (k % 9) != 8);
      tick();
    end
    ld_req = 1'b0; if_req = 1'b0;
    ref_mem[8] = 32'h1234_5678;
    tick();

    // 4: bad addresses
    if_req = 1'b1; if_addr = 64'h201;
    #1 check("bad_if_gnt", if_gnt, 1);
    check("bad_ren", mem_read_en, 0);
    tick();
    if_addr = 64'h3;
    #1 check("bad_if_gnt2", if_gnt, 1);
    check("bad_ren2", mem_read_en, 0);
    tick();
    if_req = 1'b0;
    ld_req = 1'b1; ld_addr = 64'h1000;
    #1 check("bad_ld_gnt", ld_gnt, 1);
    check("bad_wen", mem_write_en, 0);
    tick();
    ld_req = 1'b0;
    check("bad_load_count", load_count, 4);
    tick();

    // 5: streaming fetch then back to BOOT through DRAIN
    if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_addr = 64'(2 * k);
      tick();
    end
    if_addr = 64'h0; boot_mode = 1'b1;
    #1 check("trans_if_gnt", if_gnt, 0);
    check("trans_ld_gnt", ld_gnt, 0);
    tick();
    check("drain_core_run", core_run, 0);
    check("drain_if_gnt", if_gnt, 0);
    tick();
    check("boot_clr_count", load_count, 0);
    check("boot_if_gnt_held", if_gnt, 0);
    if_req = 1'b0;
    ld_req = 1'b1; ld_addr = 64'h1000;
    #1 check("boot_bad_ld_gnt", ld_gnt, 1);
    check("boot_bad_wen", mem_write_en, 0);
    tick();
    check("boot_bad_count", load_count, 0);
    ld_addr = 64'h0; ld_data = 32'h55; ld_last = 1'b1;
    ref_mem[0] = 32'h55;
    tick();
    check("boot_hold_count", load_count, 1);
    check("boot_hold_core_run", core_run, 0);
    ld_last = 1'b0; boot_mode = 1'b0;

    // 6: reset during BOOT with a loader request pending
    ld_req = 1'b1; ld_addr = 64'h2; ld_data = 32'h66;
    rst_n = 1'b0;
    #1 check("rst6_ld_gnt", ld_gnt, 0);
    check("rst6_count", load_count, 0);
    check("rst6_core_run", core_run, 0);
    check("rst6_rvalid", if_rvalid, 0);
    check("rst6_rdata", if_rdata, 0);
    tick();
    check("rst6_ld_gnt_held", ld_gnt, 0);
    rst_n = 1'b1;
    #1 check("rst6_inactive", ld_gnt, 0);
    tick();
    check("rst6_ld_gnt_back", ld_gnt, 1);
    ref_mem[1] = 32'h66;
    tick();
    check("rst6_count1", load_count, 1);
    ld_addr = 64'h4; ld_data = 32'h77; ld_last = 1'b1;
    ref_mem[2] = 32'h77;
    tick();
    ld_req = 1'b0; ld_last = 1'b0;
    check("rerun_core_run", core_run, 1);
    check("rerun_count", load_count, 2);
    if_req = 1'b1; if_addr = 64'h4;
    tick();
    if_addr = 64'h2;
    tick();
    if_req = 1'b0;

    // Write then read of the same word on consecutive cycles
    ld_req = 1'b1; ld_addr = 64'h6; ld_data = 32'h88;
    ref_mem[3] = 32'h88;
    #1 check("wr_ld_gnt", ld_gnt, 1);
    tick();
    ld_req = 1'b0; if_req = 1'b1; if_addr = 64'h6;
    tick();
    if_req = 1'b0;
    tick();
    tick();
    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
